// File: rtl/inv_cmd_frontend.sv
// rtl/inv_cmd_frontend.sv - synchronised, debounced operator front end issuing valid/ready commands
module inv_cmd_frontend #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mode_sw,
   input  logic       cq_sw,
   input  logic [7:0] in_sw,
   input  logic       save_btn_n,
   input  logic       submit_btn_n,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic       cmd_mode,
   output logic [7:0] cmd_code,
   output logic [7:0] cmd_quant,
   output logic       code_loaded,
   output logic       quant_loaded,
   output logic       err_pulse
);

   typedef enum logic {IDLE, ISSUE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   // Button bits (active-low) rest at "released" so reset does not look like a press.
   localparam logic [11:0] SYNC_RST = 12'b0000_0000_0011;

   // Bundle layout: {mode, cq, data[7:0], save_n, submit_n}
   logic [11:0] meta_q, meta_d, sync_q, sync_d;
   logic        mode_s, cq_s;
   logic [7:0]  data_s;
   logic [1:0]  btn_s;            // [0] save, [1] submit
   logic [1:0]  lvl_q, lvl_d;
   logic [1:0]  press_q, press_d;
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];

   state_t     state_q, state_d;
   logic [7:0] code_q, code_d, quant_q, quant_d;
   logic       code_l_q, code_l_d, quant_l_q, quant_l_d;
   logic       valid_q, valid_d, mode_q, mode_d, err_q, err_d;
   logic [7:0] cmd_code_q, cmd_code_d, cmd_quant_q, cmd_quant_d;

   assign mode_s = sync_q[11];
   assign cq_s   = sync_q[10];
   assign data_s = sync_q[9:2];
   assign btn_s  = {sync_q[0], sync_q[1]};

   // Two-stage synchroniser for every asynchronous input
   always_comb begin
      meta_d = {mode_sw, cq_sw, in_sw, save_btn_n, submit_btn_n};
      sync_d = meta_q;
   end

   // Per-button debounce: accept a new level only after it has persisted long enough
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         lvl_d[i] = lvl_q[i];
         cnt_d[i] = '0;
         if (btn_s[i] != lvl_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               lvl_d[i] = btn_s[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
         press_d[i] = lvl_q[i] & ~lvl_d[i];
      end
   end

   // Command FSM: collect code/quantity in IDLE, hold the command in ISSUE until accepted
   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      quant_d     = quant_q;
      code_l_d    = code_l_q;
      quant_l_d   = quant_l_q;
      valid_d     = valid_q;
      mode_d      = mode_q;
      cmd_code_d  = cmd_code_q;
      cmd_quant_d = cmd_quant_q;
      err_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (press_q[0]) begin
               if (cq_s) begin
                  code_d   = data_s;
                  code_l_d = 1'b1;
               end else begin
                  quant_d   = data_s;
                  quant_l_d = 1'b1;
               end
            end
            // SUBMIT judges completeness on the flags as they were before this edge
            if (press_q[1]) begin
               if (code_l_q && quant_l_q) begin
                  mode_d      = mode_s;
                  cmd_code_d  = code_q;
                  cmd_quant_d = quant_q;
                  valid_d     = 1'b1;
                  state_d     = ISSUE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (valid_q && cmd_ready) begin
               valid_d   = 1'b0;
               code_l_d  = 1'b0;
               quant_l_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q      <= SYNC_RST;
         sync_q      <= SYNC_RST;
         lvl_q       <= 2'b11;
         press_q     <= 2'b00;
         cnt_q[0]    <= '0;
         cnt_q[1]    <= '0;
         state_q     <= IDLE;
         code_q      <= '0;
         quant_q     <= '0;
         code_l_q    <= 1'b0;
         quant_l_q   <= 1'b0;
         valid_q     <= 1'b0;
         mode_q      <= 1'b0;
         cmd_code_q  <= '0;
         cmd_quant_q <= '0;
         err_q       <= 1'b0;
      end else begin
         meta_q      <= meta_d;
         sync_q      <= sync_d;
         lvl_q       <= lvl_d;
         press_q     <= press_d;
         cnt_q[0]    <= cnt_d[0];
         cnt_q[1]    <= cnt_d[1];
         state_q     <= state_d;
         code_q      <= code_d;
         quant_q     <= quant_d;
         code_l_q    <= code_l_d;
         quant_l_q   <= quant_l_d;
         valid_q     <= valid_d;
         mode_q      <= mode_d;
         cmd_code_q  <= cmd_code_d;
         cmd_quant_q <= cmd_quant_d;
         err_q       <= err_d;
      end
   end

   assign cmd_valid    = valid_q;
   assign cmd_mode     = mode_q;
   assign cmd_code     = cmd_code_q;
   assign cmd_quant    = cmd_quant_q;
   assign code_loaded  = code_l_q;
   assign quant_loaded = quant_l_q;
   assign err_pulse    = err_q;

endmodule

// File: tb/tb_inv_cmd_frontend.sv
// tb/tb_inv_cmd_frontend.sv - directed table-driven bench for inv_cmd_frontend
module tb_inv_cmd_frontend;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mode_sw = 1'b0, cq_sw = 1'b0;
   logic [7:0] in_sw = 8'h00;
   logic       save_btn_n = 1'b1, submit_btn_n = 1'b1;
   logic       cmd_valid, cmd_ready = 1'b0, cmd_mode;
   logic [7:0] cmd_code, cmd_quant;
   logic       code_loaded, quant_loaded, err_pulse;

   int checks = 0;
   int failures = 0;
   int err_cnt = 0, err_long = 0, hs_cnt = 0;
   logic       err_prev = 1'b0;
   logic       hs_mode;
   logic [7:0] hs_code, hs_quant;

   inv_cmd_frontend #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .mode_sw(mode_sw), .cq_sw(cq_sw), .in_sw(in_sw),
      .save_btn_n(save_btn_n), .submit_btn_n(submit_btn_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
      .cmd_code(cmd_code), .cmd_quant(cmd_quant), .code_loaded(code_loaded),
      .quant_loaded(quant_loaded), .err_pulse(err_pulse)
   );

   always #5 clk = ~clk;

   // Event monitor: counts error pulses, over-long pulses and completed handshakes
   always @(posedge clk) begin
      if (err_pulse) err_cnt = err_cnt + 1;
      if (err_pulse && err_prev) err_long = err_long + 1;
      err_prev = err_pulse;
      if (cmd_valid && cmd_ready) begin
         hs_cnt   = hs_cnt + 1;
         hs_mode  = cmd_mode;
         hs_code  = cmd_code;
         hs_quant = cmd_quant;
      end
   end

   typedef struct {
      bit sub; bit cq; bit mode; logic [7:0] data;
      bit e_cl; bit e_ql; int e_err; int e_hs;
      bit e_mode; logic [7:0] e_code; logic [7:0] e_quant;
   } vec_t;
   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      save_btn_n = 1'b1; submit_btn_n = 1'b1; cmd_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic press(input bit which, input int hold);
      if (which) submit_btn_n = 1'b0; else save_btn_n = 1'b0;
      repeat (hold) @(negedge clk);
      submit_btn_n = 1'b1; save_btn_n = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic save(input bit cq, input logic [7:0] d);
      cq_sw = cq; in_sw = d;
      @(negedge clk);
      press(1'b0, 10);
   endtask

   int e0, h0;

   initial begin
      //           sub cq md data   cl ql err hs md code   quant
      tbl[0] = '{1, 0, 1, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'h00};
      tbl[1] = '{0, 1, 0, 8'h05, 1, 0, 0, 0, 0, 8'h00, 8'h00};
      tbl[2] = '{1, 0, 1, 8'h00, 1, 0, 1, 0, 0, 8'h00, 8'h00};
      tbl[3] = '{0, 0, 1, 8'h10, 1, 1, 0, 0, 0, 8'h00, 8'h00};
      tbl[4] = '{0, 1, 1, 8'h07, 1, 1, 0, 0, 0, 8'h00, 8'h00};
      tbl[5] = '{1, 1, 0, 8'hEE, 0, 0, 0, 1, 0, 8'h07, 8'h10};
      tbl[6] = '{0, 0, 0, 8'hFF, 0, 1, 0, 0, 0, 8'h00, 8'h00};
      tbl[7] = '{0, 1, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 8'h00};
      tbl[8] = '{1, 0, 1, 8'h99, 0, 0, 0, 1, 1, 8'h00, 8'hFF};

      repeat (2) @(negedge clk);
      chk("rst_valid", cmd_valid, 0);
      chk("rst_outputs", {cmd_mode, cmd_code, cmd_quant, code_loaded, quant_loaded, err_pulse}, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Table of single button operations, core always ready
      cmd_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         e0 = err_cnt; h0 = hs_cnt;
         cq_sw = tbl[i].cq; mode_sw = tbl[i].mode; in_sw = tbl[i].data;
         @(negedge clk);
         press(tbl[i].sub, 10);
         chk($sformatf("v%0d_code_loaded", i), code_loaded, tbl[i].e_cl);
         chk($sformatf("v%0d_quant_loaded", i), quant_loaded, tbl[i].e_ql);
         chk($sformatf("v%0d_err", i), err_cnt - e0, tbl[i].e_err);
         chk($sformatf("v%0d_hs", i), hs_cnt - h0, tbl[i].e_hs);
         chk($sformatf("v%0d_valid", i), cmd_valid, 0);
         if (tbl[i].e_hs == 1)
            chk($sformatf("v%0d_fields", i), {hs_mode, hs_code, hs_quant},
                {tbl[i].e_mode, tbl[i].e_code, tbl[i].e_quant});
      end

      // Bounce rejection
      do_reset();
      cq_sw = 1'b1; in_sw = 8'h2A;
      for (int k = 0; k < 5; k++) begin
         save_btn_n = 1'b0; repeat (2) @(negedge clk);
         save_btn_n = 1'b1; repeat (2) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      chk("bounce_no_event", code_loaded, 0);
      press(1'b0, 10);
      chk("bounce_code_loaded", {code_loaded, quant_loaded}, 2'b10);
      save(1'b0, 8'h01);
      cmd_ready = 1'b1; mode_sw = 1'b1;
      h0 = hs_cnt;
      press(1'b1, 10);
      chk("bounce_hs", hs_cnt - h0, 1);
      chk("bounce_code", hs_code, 8'h2A);

      // Full add with a slow core, then frozen registers during ISSUE
      do_reset();
      save(1'b1, 8'h05);
      save(1'b0, 8'h10);
      mode_sw = 1'b1; cmd_ready = 1'b0;
      e0 = err_cnt; h0 = hs_cnt;
      press(1'b1, 10);
      for (int k = 0; k < 3; k++) begin
         chk("issue_valid", cmd_valid, 1);
         chk("issue_fields", {cmd_mode, cmd_code, cmd_quant}, {1'b1, 8'h05, 8'h10});
         @(negedge clk);
      end
      mode_sw = 1'b0;
      save(1'b0, 8'hFF);
      press(1'b1, 10);
      chk("frozen_quant", cmd_quant, 8'h10);
      chk("frozen_mode", cmd_mode, 1);
      chk("frozen_valid", cmd_valid, 1);
      chk("frozen_no_err", err_cnt - e0, 0);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      chk("hs_valid_drop", cmd_valid, 0);
      chk("hs_flags_clear", {code_loaded, quant_loaded}, 2'b00);
      repeat (20) @(negedge clk);
      chk("one_command", hs_cnt - h0, 1);
      chk("one_command_valid", cmd_valid, 0);

      // Reset in the middle of ISSUE
      save(1'b1, 8'h0C);
      save(1'b0, 8'h0D);
      press(1'b1, 10);
      chk("pre_reset_valid", cmd_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_valid", cmd_valid, 0);
      chk("async_reset_state", {code_loaded, quant_loaded, cmd_code, cmd_quant}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      e0 = err_cnt;
      press(1'b1, 10);
      chk("post_reset_err", err_cnt - e0, 1);
      chk("post_reset_valid", cmd_valid, 0);

      // Simultaneous SAVE and SUBMIT: submit uses the old flags
      do_reset();
      save(1'b1, 8'h33);
      cq_sw = 1'b0; in_sw = 8'h44; cmd_ready = 1'b1;
      @(negedge clk);
      e0 = err_cnt; h0 = hs_cnt;
      save_btn_n = 1'b0; submit_btn_n = 1'b0;
      repeat (10) @(negedge clk);
      save_btn_n = 1'b1; submit_btn_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("same_cycle_err", err_cnt - e0, 1);
      chk("same_cycle_flags", {code_loaded, quant_loaded}, 2'b11);
      chk("same_cycle_no_hs", hs_cnt - h0, 0);

      // Held SUBMIT produces exactly one command
      h0 = hs_cnt;
      press(1'b1, 100);
      chk("held_one_hs", hs_cnt - h0, 1);
      chk("held_fields", {hs_code, hs_quant}, {8'h33, 8'h44});
      chk("err_pulse_width", err_long, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inv_cmd_frontend.md
Name: inv_cmd_frontend

Overview:
- Operator-input front end of the inventory design, directly upstream of the inventory core.
- Synchronises and debounces the SAVE and SUBMIT pushbuttons and latches item code and quantity from the 8 switches.
- Issues one complete add/remove command per SUBMIT press to the core over a valid/ready handshake, so the core no longer uses raw button edges as clocks.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable samples before a button level is accepted (5 ms at 50 MHz).
- CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- mode_sw  in  1  1 = add, 0 = remove; asynchronous switch
- cq_sw  in  1  1 = SAVE targets code, 0 = SAVE targets quantity; asynchronous switch
- in_sw  in  8  data switches; asynchronous
- save_btn_n  in  1  SAVE pushbutton, active-low, bouncing
- submit_btn_n  in  1  SUBMIT pushbutton, active-low, bouncing
- cmd_valid  out  1  command offered to the core
- cmd_ready  in  1  core accepts the command
- cmd_mode  out  1  add/remove, captured at the SUBMIT press
- cmd_code  out  8  item code
- cmd_quant  out  8  quantity
- code_loaded  out  1  a code has been saved since the last issued command
- quant_loaded  out  1  a quantity has been saved since the last issued command
- err_pulse  out  1  one-cycle pulse when SUBMIT is rejected

Behaviour:
- Reset: asynchronous on rst_n low. All outputs and internal registers clear to 0. Debounced button levels reset to "released" (1). FSM goes to IDLE.
- Synchronisation:
  - Every asynchronous input (mode_sw, cq_sw, in_sw, both buttons) passes through a 2-flop synchroniser.
  - All decisions use only the synchronised values.
- Debounce, per button:
  - A counter increments while the synchronised level differs from the accepted level, and clears to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the level still differs, the accepted level takes the new value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles leaves the accepted level unchanged.
- Press event: a one-cycle pulse on the accepted level's 1->0 transition. Releases generate nothing. Holding a button generates exactly one event.
- Total latency from a clean press edge to the press pulse: 2 + DEBOUNCE_CYCLES cycles.
- SAVE event, honoured only in IDLE:
  - cq_sw=1: code_reg <= in_sw and code_loaded <= 1.
  - cq_sw=0: quant_reg <= in_sw and quant_loaded <= 1.
  - mode_sw is ignored. Re-saving overwrites the register.
  - In ISSUE, SAVE events are dropped and the registers stay frozen.
- FSM state IDLE:
  - cmd_valid = 0.
  - SUBMIT event with code_loaded && quant_loaded: capture cmd_mode <= mode_sw, drive cmd_code/cmd_quant from the registers, go to ISSUE.
  - SUBMIT event with either flag 0: err_pulse = 1 for one cycle; stay in IDLE with the flags unchanged.
- FSM state ISSUE:
  - cmd_valid = 1. cmd_mode, cmd_code and cmd_quant are held stable.
  - On cmd_valid && cmd_ready at a clock edge: clear both loaded flags, cmd_valid <= 0, go to IDLE.
  - If cmd_ready is already high on entry, the transfer completes on the first ISSUE cycle.
  - SUBMIT events are ignored; no err_pulse is raised.
  - cmd_valid never drops without a handshake.
- Same-cycle SAVE and SUBMIT events in IDLE: SUBMIT is evaluated using the flag values from before this edge. SAVE still updates its register and flag.
- Reset asserted mid-ISSUE: the command is abandoned, cmd_valid drops immediately (asynchronously), and the flags clear.
- Data values are unsigned 8-bit and are passed through unmodified. Saturation remains the core's job.

Test Plan (DEBOUNCE_CYCLES=4):
- Bounce rejection: save_btn_n toggling 1/0 every 2 cycles for 20 cycles, then held 0 -> exactly one SAVE event. With cq_sw=1, in_sw=0x2A, code_reg becomes 0x2A and code_loaded=1.
- Full add: save code 0x05 (cq_sw=1), save quant 0x10 (cq_sw=0), mode_sw=1, press SUBMIT, cmd_ready=0 for 3 cycles then 1 -> cmd_valid high, fields stable at mode=1/code=0x05/quant=0x10 until the handshake. Both flags are 0 the cycle after.
- Incomplete submit: only a code saved, then SUBMIT -> err_pulse high for exactly 1 cycle, cmd_valid stays 0, code_loaded stays 1.
- Frozen during ISSUE: cmd_ready held 0; SAVE quant 0xFF and SUBMIT pressed again -> cmd_quant stays 0x10, no err_pulse, one command only.
- Reset mid-ISSUE: rst_n pulled low while cmd_valid=1 -> cmd_valid, flags and fields are 0 before the next clk edge. After release, SUBMIT gives err_pulse.
- Held button: submit_btn_n held low for 100 cycles with both flags set and cmd_ready=1 -> exactly one handshake.
